stage3_ex_fu_pipe: RTL and testbench
====================================

Name: stage3_ex_fu_pipe

Overview:
Parametrised execute-stage back end for the 3-stage pipeline. Issues one decoded operation per cycle to one of NUM_FU functional units: FU0 is the single-cycle ALU, the rest are multi-cycle with a start/busy handshake (e.g. RV32M). Results are captured into a DEPTH-deep execute→memory register chain with stall and flush. The block also answers rs1/rs2 forwarding lookups against every in-flight stage.

Parameters:
NUM_FU, 4, number of functional units (≥2); FU0 is combinational and single-cycle.
WORD_W, 32, data and PC width.
DEPTH, 2, number of result register stages (≥1); the last stage drives out_*.

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  operation accepted this cycle when in_valid&in_ready
in_fu_sel  input  $clog2(NUM_FU)  target FU index
in_rd  input  5  destination register
in_reg_write  input  1  writes rd
in_pc  input  WORD_W  instruction PC
fu_start  output  NUM_FU  one-cycle start pulse per FU (bit 0 never set)
fu_abort  output  NUM_FU  one-cycle abort pulse to the in-flight FU on flush
fu_busy  input  NUM_FU  FU busy; bit 0 ignored
fu_result  input  NUM_FU*WORD_W  FU results, FU i at [i*WORD_W +: WORD_W]
stall  input  1  hold all stages
flush  input  1  kill all in-flight work
ex_busy  output  1  multi-cycle operation outstanding
lookup_rs1, lookup_rs2  input  5  forwarding lookup registers
fwd_rs1_hit, fwd_rs2_hit  output  1  match found
fwd_rs1_data, fwd_rs2_data  output  WORD_W  matched data
out_valid, out_reg_write  output  1  last-stage controls
out_rd  output  5  last-stage rd
out_pc, out_data  output  WORD_W  last-stage PC and result

Behaviour:
- Reset: state IDLE; all stage valid/reg_write/rd/pc/data = 0; fu_start = fu_abort = 0; all out_* = 0; ex_busy = 0.
- FSM states: IDLE, WAIT, HOLD. Saved context: fu index, rd, reg_write, pc, result.
- in_ready = (state==IDLE) && !stall && !flush.
- IDLE, accept with sel==0: fu_result[0] enters stage 0 at the next edge. Latency 1 to stage 0, DEPTH to out_*.
- IDLE, accept with sel≠0: fu_start[sel]=1 in the accept cycle (combinational); save context; go to WAIT.
- WAIT: fu_busy[sel] is ignored in the first cycle after start. From then on, fu_busy[sel]==0 means done:
  - done and !stall: push saved context plus fu_result[sel] into stage 0; go to IDLE.
  - done and stall: latch the result; go to HOLD.
- HOLD: on !stall, push the latched entry into stage 0; go to IDLE.
- ex_busy = (state!=IDLE).
- Stage shift: on !stall, stage k+1 <= stage k. Stage 0 gets the new entry, or a bubble (valid=0) if none. On stall, all stages hold.
- Flush beats stall:
  - all stage valid <= 0; FSM <= IDLE.
  - In WAIT, fu_abort[sel]=1 for that cycle.
  - An in_valid in the flush cycle is not accepted.
- Forwarding per lookup:
  - Scan stage 0 (youngest) to stage DEPTH-1; take the first stage with valid && reg_write && rd==lookup && lookup≠0.
  - No match: hit=0, data=0.
  - Purely combinational. The FSM saved context is never forwarded; the hazard unit stalls on ex_busy instead.
- Out-of-range in_fu_sel (≥NUM_FU) is treated as FU0.

Optional Feature:
STAGE3_FU_PERF_EN
- Defined: adds output fu_busy_cycles, width NUM_FU*32.
  - One saturating counter per FU; increments every cycle that FU is in WAIT or HOLD.
  - Counters reset to 0 and are not cleared by flush.
- Undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
- DEPTH=2, ALU op (sel 0, rd 5, result 0x1234) with no stall -> out_valid=1, out_rd=5, out_data=0x1234 two cycles after accept; fwd_rs1_hit=1 for lookup 5 in both intermediate cycles.
- sel 1, fu_busy[1] high for 3 cycles after start, result 0xDEAD -> fu_start[1] pulses once; ex_busy=1 and in_ready=0 until done; out_data=0xDEAD at DEPTH cycles after done.
- FU1 done while stall=1 for 2 cycles -> FSM goes to HOLD; entry enters stage 0 on the first cycle stall=0; no data lost or duplicated.
- flush asserted in WAIT on FU2 -> fu_abort[2] pulses once; all out_valid=0; in_ready=1 next cycle; the late fu_result is never captured.
- Two writers to rd 7 in stages 0 and 1 with data 0x1 and 0x2 -> fwd data = 0x1; lookup 0 -> hit=0.
- Async nRST low mid-WAIT -> all outputs 0 immediately, state IDLE, no fu_start on release.

Source files
------------

// File: rtl/stage3_ex_fu_pipe.sv
// stage3_ex_fu_pipe: execute-stage back end for the 3-stage pipeline.
// Issues one operation per cycle to NUM_FU functional units. FU0 is a
// single-cycle ALU. The other FUs are multi-cycle and use a start/busy handshake.
// Results travel down a DEPTH-deep result register chain that supports stall and flush.
// The block also answers rs1/rs2 forwarding lookups against every stage.
// Optional feature macro: STAGE3_FU_PERF_EN adds per-FU busy-cycle counters.
module stage3_ex_fu_pipe #(
   parameter int NUM_FU = 4,
   parameter int WORD_W = 32,
   parameter int DEPTH  = 2,
   localparam int SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         in_fu_sel,
   input  logic [4:0]               in_rd,
   input  logic                     in_reg_write,
   input  logic [WORD_W-1:0]        in_pc,
   output logic [NUM_FU-1:0]        fu_start,
   output logic [NUM_FU-1:0]        fu_abort,
   input  logic [NUM_FU-1:0]        fu_busy,
   input  logic [NUM_FU*WORD_W-1:0] fu_result,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     ex_busy,
   input  logic [4:0]               lookup_rs1,
   input  logic [4:0]               lookup_rs2,
   output logic                     fwd_rs1_hit,
   output logic                     fwd_rs2_hit,
   output logic [WORD_W-1:0]        fwd_rs1_data,
   output logic [WORD_W-1:0]        fwd_rs2_data,
`ifdef STAGE3_FU_PERF_EN
   output logic [NUM_FU*32-1:0]     fu_busy_cycles,
`endif
   output logic                     out_valid,
   output logic                     out_reg_write,
   output logic [4:0]               out_rd,
   output logic [WORD_W-1:0]        out_pc,
   output logic [WORD_W-1:0]        out_data
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t            r_state, w_nextState;
   logic [SEL_W-1:0]  r_sel, w_selEff;
   logic              r_first;
   logic [4:0]        r_rd;
   logic              r_regW;
   logic [WORD_W-1:0] r_pc, r_res;

   logic              w_accept, w_done, w_push;
   logic [4:0]        w_pushRd;
   logic              w_pushRegW;
   logic [WORD_W-1:0] w_pushPc, w_pushData, w_fuRes;

   logic              r_stValid [DEPTH];
   logic              r_stRegW  [DEPTH];
   logic [4:0]        r_stRd    [DEPTH];
   logic [WORD_W-1:0] r_stPc    [DEPTH];
   logic [WORD_W-1:0] r_stData  [DEPTH];

   assign in_ready = (r_state == IDLE) && !stall && !flush;
   assign w_accept = in_valid && in_ready;
   assign ex_busy  = (r_state != IDLE);
   assign w_fuRes  = fu_result[int'(r_sel)*WORD_W +: WORD_W];
   assign w_done   = (r_state == WAIT) && !r_first && !fu_busy[r_sel];

   // Map out-of-range FU selects onto the ALU.
   always_comb begin
      w_selEff = in_fu_sel;
      if (int'(in_fu_sel) >= NUM_FU) w_selEff = '0;
   end

   // Next-state, start/abort pulses and the entry pushed into stage 0.
   always_comb begin
      w_nextState = r_state;
      fu_start    = '0;
      fu_abort    = '0;
      w_push      = 1'b0;
      w_pushRd    = r_rd;
      w_pushRegW  = r_regW;
      w_pushPc    = r_pc;
      w_pushData  = r_res;
      if (flush) begin
         w_nextState = IDLE;
         if (r_state == WAIT) fu_abort[r_sel] = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_selEff == '0) begin
                     w_push     = 1'b1;
                     w_pushRd   = in_rd;
                     w_pushRegW = in_reg_write;
                     w_pushPc   = in_pc;
                     w_pushData = fu_result[WORD_W-1:0];
                  end else begin
                     fu_start[w_selEff] = 1'b1;
                     w_nextState        = WAIT;
                  end
               end
            end
            WAIT: begin
               if (w_done) begin
                  if (!stall) begin
                     w_push      = 1'b1;
                     w_pushData  = w_fuRes;
                     w_nextState = IDLE;
                  end else begin
                     w_nextState = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  w_push      = 1'b1;
                  w_nextState = IDLE;
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Saved multi-cycle context. The result is latched when completion collides with a stall.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_sel   <= '0;
         r_first <= 1'b0;
         r_rd    <= '0;
         r_regW  <= 1'b0;
         r_pc    <= '0;
         r_res   <= '0;
      end else if (!flush) begin
         if ((r_state == IDLE) && w_accept && (w_selEff != '0)) begin
            r_sel   <= w_selEff;
            r_first <= 1'b1;
            r_rd    <= in_rd;
            r_regW  <= in_reg_write;
            r_pc    <= in_pc;
         end else if (r_state == WAIT) begin
            r_first <= 1'b0;
            if (w_done && stall) r_res <= w_fuRes;
         end
      end
   end

   // Result register chain: flush kills everything, stall freezes, otherwise shift.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_stValid[k] <= 1'b0;
            r_stRegW[k]  <= 1'b0;
            r_stRd[k]    <= '0;
            r_stPc[k]    <= '0;
            r_stData[k]  <= '0;
         end
      end else if (flush) begin
         for (int k = 0; k < DEPTH; k++) r_stValid[k] <= 1'b0;
      end else if (!stall) begin
         for (int k = 1; k < DEPTH; k++) begin
            r_stValid[k] <= r_stValid[k-1];
            r_stRegW[k]  <= r_stRegW[k-1];
            r_stRd[k]    <= r_stRd[k-1];
            r_stPc[k]    <= r_stPc[k-1];
            r_stData[k]  <= r_stData[k-1];
         end
         r_stValid[0] <= w_push;
         r_stRegW[0]  <= w_pushRegW;
         r_stRd[0]    <= w_pushRd;
         r_stPc[0]    <= w_pushPc;
         r_stData[0]  <= w_pushData;
      end
   end

   // Forwarding scan: the loop walks oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_rs1_hit  = 1'b0;
      fwd_rs1_data = '0;
      fwd_rs2_hit  = 1'b0;
      fwd_rs2_data = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (r_stValid[k] && r_stRegW[k] && (r_stRd[k] == lookup_rs1) && (lookup_rs1 != 5'd0)) begin
            fwd_rs1_hit  = 1'b1;
            fwd_rs1_data = r_stData[k];
         end
         if (r_stValid[k] && r_stRegW[k] && (r_stRd[k] == lookup_rs2) && (lookup_rs2 != 5'd0)) begin
            fwd_rs2_hit  = 1'b1;
            fwd_rs2_data = r_stData[k];
         end
      end
   end

   assign out_valid     = r_stValid[DEPTH-1];
   assign out_reg_write = r_stRegW[DEPTH-1];
   assign out_rd        = r_stRd[DEPTH-1];
   assign out_pc        = r_stPc[DEPTH-1];
   assign out_data      = r_stData[DEPTH-1];

`ifdef STAGE3_FU_PERF_EN
   logic [31:0] r_busyCnt [NUM_FU];

   // Saturating per-FU busy-cycle counters. A flush does not clear them.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_FU; i++) r_busyCnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if ((r_state != IDLE) && (int'(r_sel) == i) && (r_busyCnt[i] != 32'hFFFF_FFFF))
               r_busyCnt[i] <= r_busyCnt[i] + 32'd1;
         end
      end
   end

   // Pack the counters onto the flat output port.
   always_comb begin
      fu_busy_cycles = '0;
      for (int i = 0; i < NUM_FU; i++) fu_busy_cycles[i*32 +: 32] = r_busyCnt[i];
   end
`endif

endmodule

// File: tb/tb_stage3_ex_fu_pipe.sv
// Directed self-checking bench for stage3_ex_fu_pipe (NUM_FU=4, WORD_W=32, DEPTH=2).
`timescale 1ns/1ps
module tb_stage3_ex_fu_pipe;

   localparam int NUM_FU = 4;
   localparam int WORD_W = 32;
   localparam int DEPTH  = 2;

   logic                     CLK, nRST;
   logic                     in_valid, in_ready, in_reg_write;
   logic [1:0]               in_fu_sel;
   logic [4:0]               in_rd;
   logic [WORD_W-1:0]        in_pc;
   logic [NUM_FU-1:0]        fu_start, fu_abort, fu_busy;
   logic [NUM_FU*WORD_W-1:0] fu_result;
   logic                     stall, flush, ex_busy;
   logic [4:0]               lookup_rs1, lookup_rs2;
   logic                     fwd_rs1_hit, fwd_rs2_hit;
   logic [WORD_W-1:0]        fwd_rs1_data, fwd_rs2_data;
   logic                     out_valid, out_reg_write;
   logic [4:0]               out_rd;
   logic [WORD_W-1:0]        out_pc, out_data;

   int cmpCount = 0;
   int errCount = 0;

   stage3_ex_fu_pipe #(.NUM_FU(NUM_FU), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .nRST(nRST),
      .in_valid(in_valid), .in_ready(in_ready), .in_fu_sel(in_fu_sel),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .in_pc(in_pc),
      .fu_start(fu_start), .fu_abort(fu_abort), .fu_busy(fu_busy), .fu_result(fu_result),
      .stall(stall), .flush(flush), .ex_busy(ex_busy),
      .lookup_rs1(lookup_rs1), .lookup_rs2(lookup_rs2),
      .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
      .out_valid(out_valid), .out_reg_write(out_reg_write), .out_rd(out_rd),
      .out_pc(out_pc), .out_data(out_data)
   );

   // Free-running clock with rising edges at 5, 15, 25 ns and so on.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drive the issue-side inputs, then let the combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                                input logic rw, input logic [WORD_W-1:0] pc);
      in_valid     = v;
      in_fu_sel    = sel;
      in_rd        = rd;
      in_reg_write = rw;
      in_pc        = pc;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmpCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      nRST = 1'b0; stall = 1'b0; flush = 1'b0; fu_busy = '0; fu_result = '0;
      lookup_rs1 = '0; lookup_rs2 = '0;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      #1;
      $display("[TB] reset checks");
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_ex_busy",   64'(ex_busy),   64'd0);
      checkOutput("rst_out_data",  64'(out_data),  64'd0);
      checkOutput("rst_fu_start",  64'(fu_start),  64'd0);
      checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
      nRST = 1'b1;

      // ALU op: rd 5 with result 0x1234. It reaches the output two edges after acceptance.
      tick();
      fu_result[0 +: WORD_W] = 32'h1234;
      lookup_rs1 = 5'd5;
      applyStimulus(1'b1, 2'd0, 5'd5, 1'b1, 32'h100);
      checkOutput("alu_in_ready", 64'(in_ready), 64'd1);
      checkOutput("alu_fu_start", 64'(fu_start), 64'd0);
      tick();
      fu_result[0 +: WORD_W] = 32'h0;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      checkOutput("alu_fwd_s0_hit",  64'(fwd_rs1_hit),  64'd1);
      checkOutput("alu_fwd_s0_data", 64'(fwd_rs1_data), 64'h1234);
      checkOutput("alu_early_valid", 64'(out_valid),    64'd0);
      tick();
      checkOutput("alu_out_valid",  64'(out_valid),    64'd1);
      checkOutput("alu_out_rd",     64'(out_rd),       64'd5);
      checkOutput("alu_out_data",   64'(out_data),     64'h1234);
      checkOutput("alu_out_pc",     64'(out_pc),       64'h100);
      checkOutput("alu_fwd_s1_hit", 64'(fwd_rs1_hit),  64'd1);
      tick();
      checkOutput("alu_drain_valid", 64'(out_valid),   64'd0);
      checkOutput("alu_drain_hit",   64'(fwd_rs1_hit), 64'd0);

      // FU1 multi-cycle op: busy in cycles 1-3 after start, done in cycle 4 with 0xDEAD.
      applyStimulus(1'b1, 2'd1, 5'd9, 1'b1, 32'h200);
      checkOutput("fu1_start_pulse", 64'(fu_start), 64'h2);
      tick();
      fu_busy[1] = 1'b1;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      checkOutput("fu1_w1_busy",  64'(ex_busy),  64'd1);
      checkOutput("fu1_w1_ready", 64'(in_ready), 64'd0);
      checkOutput("fu1_w1_start", 64'(fu_start), 64'd0);
      tick();
      checkOutput("fu1_w2_start", 64'(fu_start), 64'd0);
      tick();
      checkOutput("fu1_w3_busy",  64'(ex_busy),  64'd1);
      tick();
      fu_busy[1] = 1'b0;
      fu_result[1*WORD_W +: WORD_W] = 32'hDEAD;
      #1;
      checkOutput("fu1_done_busy",  64'(ex_busy),  64'd1);
      checkOutput("fu1_done_ready", 64'(in_ready), 64'd0);
      tick();
      fu_result[1*WORD_W +: WORD_W] = 32'h0;
      #1;
      checkOutput("fu1_idle_busy",  64'(ex_busy),   64'd0);
      checkOutput("fu1_idle_ready", 64'(in_ready),  64'd1);
      checkOutput("fu1_s0_valid",   64'(out_valid), 64'd0);
      tick();
      checkOutput("fu1_out_valid", 64'(out_valid), 64'd1);
      checkOutput("fu1_out_data",  64'(out_data),  64'hDEAD);
      checkOutput("fu1_out_rd",    64'(out_rd),    64'd9);
      tick();

      // FU1 completes during a two-cycle stall. The result must survive in HOLD exactly once.
      applyStimulus(1'b1, 2'd1, 5'd10, 1'b1, 32'h300);
      tick();
      fu_busy[1] = 1'b1;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      tick();
      fu_busy[1] = 1'b0;
      fu_result[1*WORD_W +: WORD_W] = 32'hBEEF;
      stall = 1'b1;
      #1;
      checkOutput("hold_done_ready", 64'(in_ready), 64'd0);
      tick();
      fu_result[1*WORD_W +: WORD_W] = 32'h0;
      #1;
      checkOutput("hold_h1_busy", 64'(ex_busy), 64'd1);
      tick();
      stall = 1'b0;
      #1;
      checkOutput("hold_h2_busy",  64'(ex_busy),   64'd1);
      checkOutput("hold_h2_valid", 64'(out_valid), 64'd0);
      tick();
      lookup_rs1 = 5'd10;
      #1;
      checkOutput("hold_idle_busy", 64'(ex_busy),      64'd0);
      checkOutput("hold_fwd_hit",   64'(fwd_rs1_hit),  64'd1);
      checkOutput("hold_fwd_data",  64'(fwd_rs1_data), 64'hBEEF);
      tick();
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_out_data",  64'(out_data),  64'hBEEF);
      checkOutput("hold_out_pc",    64'(out_pc),    64'h300);
      tick();
      checkOutput("hold_no_dup", 64'(out_valid), 64'd0);

      // ALU op followed by an FU2 op. Flush in the first WAIT cycle kills both.
      fu_result[0 +: WORD_W] = 32'h33;
      applyStimulus(1'b1, 2'd0, 5'd3, 1'b1, 32'h500);
      tick();
      applyStimulus(1'b1, 2'd2, 5'd11, 1'b1, 32'h400);
      checkOutput("fl_fu2_start", 64'(fu_start), 64'h4);
      tick();
      fu_busy[2] = 1'b1;
      flush = 1'b1;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      checkOutput("fl_abort",      64'(fu_abort),  64'h4);
      checkOutput("fl_ready",      64'(in_ready),  64'd0);
      checkOutput("fl_pre_valid",  64'(out_valid), 64'd1);
      checkOutput("fl_pre_data",   64'(out_data),  64'h33);
      tick();
      flush = 1'b0;
      fu_busy[2] = 1'b0;
      fu_result[2*WORD_W +: WORD_W] = 32'hBAD;
      #1;
      checkOutput("fl_abort_once", 64'(fu_abort),  64'h0);
      checkOutput("fl_next_ready", 64'(in_ready),  64'd1);
      checkOutput("fl_next_busy",  64'(ex_busy),   64'd0);
      checkOutput("fl_killed",     64'(out_valid), 64'd0);
      tick();
      checkOutput("fl_late1", 64'(out_valid), 64'd0);
      tick();
      checkOutput("fl_late2", 64'(out_valid), 64'd0);

      // Two writers to rd 7. The younger value (0x1) must win, and lookup 0 never hits.
      lookup_rs1 = 5'd7;
      lookup_rs2 = 5'd0;
      fu_result[0 +: WORD_W] = 32'h2;
      applyStimulus(1'b1, 2'd0, 5'd7, 1'b1, 32'h600);
      tick();
      fu_result[0 +: WORD_W] = 32'h1;
      applyStimulus(1'b1, 2'd0, 5'd7, 1'b1, 32'h604);
      checkOutput("fw_single_data", 64'(fwd_rs1_data), 64'h2);
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      checkOutput("fw_young_hit",  64'(fwd_rs1_hit),  64'd1);
      checkOutput("fw_young_data", 64'(fwd_rs1_data), 64'h1);
      checkOutput("fw_zero_hit",   64'(fwd_rs2_hit),  64'd0);
      checkOutput("fw_zero_data",  64'(fwd_rs2_data), 64'h0);
      checkOutput("fw_out_data",   64'(out_data),     64'h2);

      // Asynchronous reset in the middle of a WAIT on FU3.
      applyStimulus(1'b1, 2'd3, 5'd12, 1'b1, 32'h700);
      checkOutput("ar_start", 64'(fu_start), 64'h8);
      tick();
      fu_busy[3] = 1'b1;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, '0);
      checkOutput("ar_pre_busy", 64'(ex_busy),  64'd1);
      checkOutput("ar_pre_data", 64'(out_data), 64'h1);
      #2;
      nRST = 1'b0;
      #1;
      checkOutput("ar_busy",  64'(ex_busy),     64'd0);
      checkOutput("ar_valid", 64'(out_valid),   64'd0);
      checkOutput("ar_data",  64'(out_data),    64'd0);
      checkOutput("ar_rd",    64'(out_rd),      64'd0);
      checkOutput("ar_fwd",   64'(fwd_rs1_hit), 64'd0);
      @(negedge CLK);
      fu_busy[3] = 1'b0;
      nRST = 1'b1;
      tick();
      checkOutput("ar_rel_start", 64'(fu_start), 64'd0);
      checkOutput("ar_rel_busy",  64'(ex_busy),  64'd0);
      checkOutput("ar_rel_ready", 64'(in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
